pingpong_bank_sched: RTL and testbench
======================================

Name: pingpong_bank_sched

Overview:
- Ping-pong scheduler for two 256-bit input BRAM banks that feed the bf16 multiplier tree.
- The host fills one bank while the other is drained to the tree as 128-bit halves, giving one half per cycle with no idle gap between batches.
- Counts tree output strobes and raises a sticky stop at the mode-dependent target.
- Sits between the host interface, the two BRAM banks, the 128-bit half mux and mul_tree_bf16.

Parameters:
- AW, 11, bank address width.
- DEPTH, 2048, 256-bit words per bank batch.
- CNT_M0, 512, output-strobe target for mode 0.
- CNT_MX, 2048, output-strobe target for modes 1–3.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_vld  in  1  host word valid
- in_ready  out  1  host word accept
- mode  in  2  tree mode; latched on first accepted word
- bank_we  out  2  one-hot write enable; bit b selects bank b
- bank_waddr  out  AW  write address, shared by both banks
- bank_re  out  2  one-hot read enable
- bank_raddr  out  AW  read address
- rd_bank  out  1  bank whose rd_data drives the half mux
- half_sel  out  1  0 = rd_data[127:0], 1 = rd_data[255:128]
- mul_stb  out  1  half valid to mul_tree_bf16
- out_vld  in  1  tree output strobe
- bank_full  out  2  per-bank FULL status
- out_cnt  out  12  accepted out_vld count
- stop  out  1  sticky done

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: in_ready=1, all other outputs 0. Both banks EMPTY, fill bank fsel=0, drain bank dsel=0, phase=0, mode latch cleared.
- Reset mid-operation aborts everything next edge. Partial bank contents are discarded and no strobe follows.
- BRAM assumptions:
  - BRAM read latency is 1.
  - rd_data holds its value while re=0.
- Per-bank state: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Fill side:
  - in_ready = !stop && bank[fsel] in {EMPTY, FILLING}.
  - Accept = in_vld & in_ready.
  - On accept: bank_we[fsel]=1 combinationally, bank_waddr = wptr.
  - Accept when wptr == DEPTH-1: bank[fsel] becomes FULL, wptr resets to 0, fsel toggles.
  - When the other bank is not EMPTY, in_ready drops the next cycle.
- Drain FSM: IDLE, RUN.
  - IDLE -> RUN when bank[dsel] is FULL and !stop. The bank becomes DRAINING.
  - RUN, phase 0 ("read" cycle):
    - bank_re[dsel]=1, bank_raddr=rptr.
    - Also the HI cycle of the previous word, if any: mul_stb=1, half_sel=1, rd_bank = previous bank.
  - RUN, phase 1: mul_stb=1, half_sel=0, rd_bank=dsel.
  - Phase toggles every RUN cycle. The first RUN cycle is phase 0 with no preceding word, so mul_stb=0.
  - Pattern per word: read at t, LO at t+1, HI at t+2. Latency from a bank going FULL to the first mul_stb is 2 cycles (IDLE detect, then read).
- End of bank, i.e. the phase-1 cycle with rptr == DEPTH-1:
  - rptr resets to 0.
  - Next cycle is the HI of the last word. On it the bank becomes EMPTY and dsel toggles.
  - If the other bank is FULL and !stop on that HI cycle, the same cycle also issues its read at address 0. Strobes stay continuous.
  - Otherwise the FSM drops to IDLE after the HI cycle.
- Simultaneous fill and drain events on the same bank cannot occur (a FILLING bank is never drained). A bank becoming FULL on the same edge the drain frees the other bank is legal. Both updates apply.
- Output count:
  - out_cnt += out_vld, saturating at 4095.
  - 12 bits so that 2048 is representable.
- Stop:
  - target = (mode_latched == 0) ? CNT_M0 : CNT_MX.
  - stop is set on the cycle after out_cnt == target and stays set until rst.
  - With stop set: in_ready=0 and no new bank drain starts. An in-flight bank drains to completion, including its last HI strobe.
- mode changes after latching are ignored until rst.

Test Plan:
- Reset then fill bank 0 with 2048 words, in_vld held high:
  - 2048 bank_we[0] pulses, waddr 0..2047.
  - bank_full=01 after the last word.
  - First mul_stb 2 cycles later.
  - Exactly 4096 mul_stb, pattern LO,HI per word.
- Continuous host input for 3 batches:
  - Bank 1 fills during the bank 0 drain.
  - mul_stb has no gap across the bank 0 -> 1 switch; rd_bank flips on the first LO of bank 1.
  - in_ready is low only while both banks are non-EMPTY.
- in_vld toggling with 30% gaps:
  - Write addresses stay contiguous.
  - No accept when in_ready=0.
  - Total strobes are unchanged.
- mode=0 with 512 forced out_vld pulses:
  - stop=1 the cycle after out_cnt==512.
  - in_ready=0.
  - A FULL bank is not drained afterwards.
- mode=2 with 2048 out_vld pulses:
  - stop asserts.
  - out_cnt reads 2048, with no wrap to 0.
- rst asserted mid-drain, word 700:
  - Next cycle: mul_stb=0, bank_re=00, bank_full=00, in_ready=1.
  - A fresh batch restarts at address 0.

Source files
------------

// File: rtl/pingpong_bank_sched_if.sv
// Host, BRAM-bank and multiplier-tree signals of the ping-pong bank scheduler.
// The scheduler binds to the slave modport; the host/bench side uses master.
interface pingpong_bank_sched_if #(
  parameter int unsigned AW = 11
);
  logic          in_vld;
  logic          in_ready;
  logic [1:0]    mode;
  logic [1:0]    bank_we;
  logic [AW-1:0] bank_waddr;
  logic [1:0]    bank_re;
  logic [AW-1:0] bank_raddr;
  logic          rd_bank;
  logic          half_sel;
  logic          mul_stb;
  logic          out_vld;
  logic [1:0]    bank_full;
  logic [11:0]   out_cnt;
  logic          stop;

  modport master (
    output in_vld, mode, out_vld,
    input  in_ready, bank_we, bank_waddr, bank_re, bank_raddr, rd_bank, half_sel, mul_stb,
           bank_full, out_cnt, stop
  );

  modport slave (
    input  in_vld, mode, out_vld,
    output in_ready, bank_we, bank_waddr, bank_re, bank_raddr, rd_bank, half_sel, mul_stb,
           bank_full, out_cnt, stop
  );
endinterface

// File: rtl/pingpong_bank_sched.sv
// Ping-pong scheduler: the host fills one 256-bit bank while the other is streamed to the
// bf16 multiplier tree as 128-bit halves; counts tree strobes and raises a sticky stop.
module pingpong_bank_sched #(
  parameter int unsigned AW     = 11,
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned CNT_M0 = 512,
  parameter int unsigned CNT_MX = 2048
) (
  input logic                  clk,
  input logic                  rst,
  pingpong_bank_sched_if.slave bus_io
);

  typedef enum logic [1:0] {BkEmpty, BkFilling, BkFull, BkDraining} bank_st_e;
  typedef enum logic [1:0] {StIdle, StRun, StTail} drain_st_e;

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
  localparam logic [11:0]   TgtM0    = 12'(CNT_M0);
  localparam logic [11:0]   TgtMx    = 12'(CNT_MX);

  bank_st_e      bank_q [2];
  drain_st_e     st_q;
  logic          fsel_q, dsel_q, phase_q;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [1:0]    mode_q;
  logic          mode_vld_q;
  logic [11:0]   cnt_q;
  logic          stop_q;
  logic [1:0]    re_q;
  logic          stb_q, half_q, rdb_q;

  logic          in_ready, accept, fill_last, stop_d;
  logic [11:0]   target;
  logic [1:0]    full_nxt;

  always_comb begin
    in_ready  = !stop_q && (bank_q[fsel_q] == BkEmpty || bank_q[fsel_q] == BkFilling);
    accept    = bus_io.in_vld && in_ready;
    fill_last = accept && (wptr_q == LastAddr);
    target    = (mode_q == 2'd0) ? TgtM0 : TgtMx;
    stop_d    = stop_q || (cnt_q == target);
    // FULL as seen after this edge, so a bank completing now can be chained without a gap
    for (int b = 0; b < 2; b++) begin
      full_nxt[b] = (bank_q[b] == BkFull) || (fill_last && (fsel_q == 1'(b)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q[0]  <= BkEmpty;
      bank_q[1]  <= BkEmpty;
      st_q       <= StIdle;
      fsel_q     <= 1'b0;
      dsel_q     <= 1'b0;
      phase_q    <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      mode_q     <= 2'd0;
      mode_vld_q <= 1'b0;
      cnt_q      <= '0;
      stop_q     <= 1'b0;
      re_q       <= 2'b00;
      stb_q      <= 1'b0;
      half_q     <= 1'b0;
      rdb_q      <= 1'b0;
    end else begin
      if (accept) begin
        if (!mode_vld_q) begin
          mode_q     <= bus_io.mode;
          mode_vld_q <= 1'b1;
        end
        if (fill_last) begin
          bank_q[fsel_q] <= BkFull;
          wptr_q         <= '0;
          fsel_q         <= ~fsel_q;
        end else begin
          bank_q[fsel_q] <= BkFilling;
          wptr_q         <= wptr_q + AW'(1);
        end
      end
      if (bus_io.out_vld && cnt_q != 12'hfff) begin
        cnt_q <= cnt_q + 12'd1;
      end
      stop_q <= stop_d;

      // Drain side; the assignments below override the fill update when a bank goes
      // FULL and is chained into DRAINING on the same edge.
      unique case (st_q)
        StIdle: begin
          re_q   <= 2'b00;
          stb_q  <= 1'b0;
          half_q <= 1'b0;
          if (bank_q[dsel_q] == BkFull && !stop_q) begin
            bank_q[dsel_q] <= BkDraining;
            st_q           <= StRun;
            phase_q        <= 1'b0;
            re_q           <= {dsel_q, ~dsel_q};
          end
        end
        StRun: begin
          stb_q <= 1'b1;
          rdb_q <= dsel_q;
          if (!phase_q) begin
            phase_q <= 1'b1;
            re_q    <= 2'b00;
            half_q  <= 1'b0;
          end else begin
            phase_q <= 1'b0;
            half_q  <= 1'b1;
            if (rptr_q != LastAddr) begin
              rptr_q <= rptr_q + AW'(1);
              re_q   <= {dsel_q, ~dsel_q};
            end else begin
              rptr_q         <= '0;
              bank_q[dsel_q] <= BkEmpty;
              dsel_q         <= ~dsel_q;
              if (full_nxt[~dsel_q] && !stop_d) begin
                bank_q[~dsel_q] <= BkDraining;
                re_q            <= {~dsel_q, dsel_q};
              end else begin
                re_q <= 2'b00;
                st_q <= StTail;
              end
            end
          end
        end
        StTail: begin
          st_q   <= StIdle;
          re_q   <= 2'b00;
          stb_q  <= 1'b0;
          half_q <= 1'b0;
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  assign bus_io.in_ready   = in_ready;
  assign bus_io.bank_we    = accept ? {fsel_q, ~fsel_q} : 2'b00;
  assign bus_io.bank_waddr = wptr_q;
  assign bus_io.bank_re    = re_q;
  assign bus_io.bank_raddr = rptr_q;
  assign bus_io.rd_bank    = rdb_q;
  assign bus_io.half_sel   = half_q;
  assign bus_io.mul_stb    = stb_q;
  assign bus_io.bank_full  = {bank_q[1] == BkFull, bank_q[0] == BkFull};
  assign bus_io.out_cnt    = cnt_q;
  assign bus_io.stop       = stop_q;

endmodule

// File: tb/tb_pingpong_bank_sched.sv
// Scoreboard bench for pingpong_bank_sched: the host driver pushes expected writes, reads
// and half strobes; a negedge monitor pops and compares whatever the scheduler presents.
module tb_pingpong_bank_sched;
  localparam int AW    = 11;
  localparam int DEPTH = 2048;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pingpong_bank_sched_if #(.AW(AW)) bus ();

  pingpong_bank_sched #(
    .AW(AW), .DEPTH(DEPTH), .CNT_M0(512), .CNT_MX(2048)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_io(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [AW+1:0] wr_q [$];
  logic [AW+1:0] rd_q [$];
  logic [1:0]    stb_q [$];
  logic [AW+1:0] e_wr, e_rd;
  logic [1:0]    e_stb;

  int acc_cnt, wr_seen, stb_seen, drained, gap_cnt, drain_limit;
  bit chk_ready, chk_gap, stb_started;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: strobes first, so a bank freed on its last HI cycle counts as drained there.
  always begin
    @(negedge clk);
    #1;
    if (bus.mul_stb) begin
      stb_started = 1'b1;
      check("stb_pending", stb_q.size() > 0, 1);
      if (stb_q.size() > 0) begin
        e_stb = stb_q.pop_front();
        check("stb_bank_half", {bus.rd_bank, bus.half_sel}, e_stb);
      end
      stb_seen++;
      if (stb_seen % (2 * DEPTH) == 0) drained++;
    end else if (chk_gap && stb_started && stb_q.size() > 0) begin
      gap_cnt++;
    end
    if (bus.bank_re != 2'b00) begin
      check("rd_pending", rd_q.size() > 0, 1);
      if (rd_q.size() > 0) begin
        e_rd = rd_q.pop_front();
        check("rd_bank_addr", {bus.bank_re, bus.bank_raddr}, e_rd);
      end
    end
    if (chk_ready) begin
      check("in_ready", bus.in_ready, int'((wr_seen / DEPTH - drained) < 2));
    end
    if (bus.bank_we != 2'b00) begin
      check("we_handshake", bus.in_vld && bus.in_ready, 1);
      check("wr_pending", wr_q.size() > 0, 1);
      if (wr_q.size() > 0) begin
        e_wr = wr_q.pop_front();
        check("wr_bank_addr", {bus.bank_we, bus.bank_waddr}, e_wr);
      end
      wr_seen++;
    end
  end

  task automatic clear_model();
    wr_q.delete();
    rd_q.delete();
    stb_q.delete();
    acc_cnt     = 0;
    wr_seen     = 0;
    stb_seen    = 0;
    drained     = 0;
    gap_cnt     = 0;
    stb_started = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst        = 1'b1;
    bus.in_vld  = 1'b0;
    bus.out_vld = 1'b0;
    @(posedge clk);
    #1;
    clear_model();
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_bank_we", bus.bank_we, 0);
    check("rst_bank_re", bus.bank_re, 0);
    check("rst_bank_full", bus.bank_full, 0);
    check("rst_mul_stb", bus.mul_stb, 0);
    check("rst_out_cnt", bus.out_cnt, 0);
    check("rst_stop", bus.stop, 0);
    check("rst_addrs", {bus.bank_waddr, bus.bank_raddr}, 0);
    check("rst_sel", {bus.rd_bank, bus.half_sel}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive_words(input int n, input int gap_pct);
    int got = 0;
    int cyc = 0;
    int b;
    while (got < n && cyc < 40000) begin
      @(posedge clk);
      #1;
      bus.in_vld = ($urandom_range(99) >= gap_pct);
      @(negedge clk);
      if (bus.in_vld && bus.in_ready) begin
        b = (acc_cnt / DEPTH) % 2;
        wr_q.push_back({1'(b), ~1'(b), AW'(acc_cnt % DEPTH)});
        acc_cnt++;
        got++;
        if (acc_cnt % DEPTH == 0 && acc_cnt / DEPTH <= drain_limit) begin
          for (int i = 0; i < DEPTH; i++) begin
            rd_q.push_back({1'(b), ~1'(b), AW'(i)});
            stb_q.push_back({1'(b), 1'b0});
            stb_q.push_back({1'(b), 1'b1});
          end
        end
      end
      cyc++;
    end
    check("drive_done", got, n);
    @(posedge clk);
    #1;
    bus.in_vld = 1'b0;
  endtask

  task automatic pulse_out(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.out_vld = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.out_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while ((stb_q.size() > 0 || rd_q.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_left", stb_q.size() + rd_q.size(), 0);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int lat;
    int cyc;
    rst         = 1'b1;
    bus.in_vld  = 1'b0;
    bus.out_vld = 1'b0;
    bus.mode    = 2'd0;
    chk_ready   = 1'b0;
    chk_gap     = 1'b0;
    drain_limit = 100;
    clear_model();

    // Single batch into bank 0: address sequence, FULL flag, 2-cycle start latency.
    do_reset();
    chk_ready = 1'b1;
    chk_gap   = 1'b1;
    drive_words(DEPTH, 0);
    @(negedge clk);
    check("full_after_fill", bus.bank_full, 2'b01);
    lat = 0;
    while (!bus.mul_stb && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("first_stb_latency", lat, 2);
    wait_idle();
    check("t1_strobes", stb_seen, 2 * DEPTH);
    check("t1_writes", wr_seen, DEPTH);
    check("t1_full_clear", bus.bank_full, 2'b00);

    // Three back-to-back batches: strobes must run without a gap across bank switches.
    do_reset();
    drive_words(3 * DEPTH, 0);
    wait_idle();
    check("t2_strobes", stb_seen, 6 * DEPTH);
    check("t2_writes", wr_seen, 3 * DEPTH);
    check("t2_gap_cycles", gap_cnt, 0);

    // Bursty host with ~30% idle cycles.
    do_reset();
    chk_gap = 1'b0;
    drive_words(2 * DEPTH, 30);
    wait_idle();
    check("t3_strobes", stb_seen, 4 * DEPTH);
    check("t3_writes", wr_seen, 2 * DEPTH);

    // Mode 0 stop at 512 while bank 0 drains and bank 1 waits FULL.
    do_reset();
    chk_ready   = 1'b0;
    drain_limit = 1;
    bus.mode    = 2'd0;
    drive_words(2 * DEPTH, 0);
    pulse_out(512);
    @(negedge clk);
    check("m0_cnt", bus.out_cnt, 512);
    check("m0_stop_not_yet", bus.stop, 0);
    @(negedge clk);
    check("m0_stop", bus.stop, 1);
    check("m0_in_ready", bus.in_ready, 0);
    wait_idle();
    repeat (20) @(negedge clk);
    check("m0_strobes", stb_seen, 2 * DEPTH);
    check("m0_bank1_kept", bus.bank_full, 2'b10);
    check("m0_ready_after", bus.in_ready, 0);
    check("m0_stop_sticky", bus.stop, 1);

    // Mode 2 latched on the first word; later mode changes ignored; counter saturates.
    do_reset();
    drain_limit = 0;
    bus.mode    = 2'd2;
    drive_words(1, 0);
    bus.mode = 2'd0;
    pulse_out(2048);
    @(negedge clk);
    check("m2_cnt", bus.out_cnt, 2048);
    check("m2_stop_not_yet", bus.stop, 0);
    @(negedge clk);
    check("m2_stop", bus.stop, 1);
    check("m2_in_ready", bus.in_ready, 0);
    pulse_out(2057);
    @(negedge clk);
    check("cnt_saturate", bus.out_cnt, 4095);

    // Reset in the middle of a drain, then a clean batch from address 0.
    do_reset();
    chk_ready   = 1'b1;
    drain_limit = 100;
    drive_words(DEPTH, 0);
    cyc = 0;
    while (stb_seen < 1400 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_word_700", stb_seen >= 1400, 1);
    do_reset();
    drive_words(DEPTH, 0);
    wait_idle();
    check("t6_strobes", stb_seen, 2 * DEPTH);
    check("t6_writes", wr_seen, DEPTH);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
